// File: rtl/csr_row_sequencer_if.sv
// Spike-event intake and entry-output link of the CSR row sequencer.
// master: the sequencer side; slave: event queue / accumulator side.
interface csr_row_sequencer_if #(
    parameter int ROW_W = 10,
    parameter int IDX_W = 10,
    parameter int WGT_W = 8
);
    logic             row_valid;
    logic [ROW_W-1:0] row_id;
    logic             row_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic [WGT_W-1:0] out_weight;
    logic             out_last;

    modport master (
        input  row_valid, row_id, out_ready,
        output row_ready, out_valid, out_index, out_weight, out_last
    );

    modport slave (
        output row_valid, row_id, out_ready,
        input  row_ready, out_valid, out_index, out_weight, out_last
    );
endinterface

// File: rtl/csr_row_sequencer.sv
// Walks one CSR row per spike event, streaming (index, weight) entries out.
// Optional perf counters: define CSR_SEQ_PERF_CNT_EN.
module csr_row_sequencer #(
    parameter int ADDR_W = 14,
    parameter int ROW_W  = 10,
    parameter int IDX_W  = 10,
    parameter int WGT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    csr_row_sequencer_if.master bus,
    output logic [ROW_W:0]    ptr_addr,
    input  logic [ADDR_W-1:0] ptr_data,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [IDX_W-1:0]  w_index,
    input  logic [WGT_W-1:0]  w_weight,
    output logic              row_done,
    output logic              err_bad_row
`ifdef CSR_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_entries,
    output logic [31:0]       perf_stalls
`endif
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_BEG, S_RD_END, S_CAPT_END, S_STREAM, S_DONE
    } state_t;

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W:0]    r_ptr_addr;
    logic [ADDR_W-1:0] r_cursor;
    logic [ADDR_W-1:0] r_end;
    logic              r_row_ready;
    logic              r_row_done;
    logic              r_err;
    logic              r_infl;
    logic              r_infl_last;
    logic [IDX_W-1:0]  r_fidx [2];
    logic [WGT_W-1:0]  r_fwgt [2];
    logic              r_flast [2];
    logic              r_rd;
    logic              r_wr;
    logic [1:0]        r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_head_last;
    logic [1:0]        w_occ;
    logic              w_issue;

    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid && bus.out_ready;
    assign w_head_last = r_flast[r_rd];
    // Slots still claimed after this cycle's pop; keeps one entry/cycle flow.
    assign w_occ   = r_count - {1'b0, w_pop} + {1'b0, r_infl};
    assign w_issue = (r_state == S_STREAM) && (r_cursor != r_end)
                     && (w_occ < 2'd2);

    assign w_addr         = r_cursor;
    assign ptr_addr       = r_ptr_addr;
    assign row_done       = r_row_done;
    assign err_bad_row    = r_err;
    assign bus.row_ready  = r_row_ready;
    assign bus.out_valid  = w_valid;
    assign bus.out_index  = r_fidx[r_rd];
    assign bus.out_weight = r_fwgt[r_rd];
    assign bus.out_last   = w_valid && w_head_last;

    // Row control: pointer lookups, cursor walk and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_ptr_addr  <= '0;
            r_cursor    <= '0;
            r_end       <= '0;
            r_row_ready <= 1'b0;
            r_row_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.row_valid && r_row_ready) begin
                        r_row       <= bus.row_id;
                        r_ptr_addr  <= {1'b0, bus.row_id};
                        r_row_ready <= 1'b0;
                        r_state     <= S_RD_BEG;
                    end else begin
                        r_row_ready <= 1'b1;
                    end
                end
                S_RD_BEG: begin
                    r_ptr_addr <= {1'b0, r_row} + (ROW_W + 1)'(1);
                    r_state    <= S_RD_END;
                end
                S_RD_END: begin
                    r_cursor <= ptr_data;
                    r_state  <= S_CAPT_END;
                end
                S_CAPT_END: begin
                    r_end <= ptr_data;
                    if (ptr_data == r_cursor) begin
                        r_row_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (ptr_data < r_cursor) begin
                        r_err      <= 1'b1;
                        r_row_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_issue) begin
                        r_cursor <= r_cursor + ADDR_W'(1);
                    end
                    if (w_pop && w_head_last) begin
                        r_row_done <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_row_done  <= 1'b0;
                    r_row_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read tracking and the 2-entry output FIFO fed one cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_fidx[0]   <= '0;
            r_fidx[1]   <= '0;
            r_fwgt[0]   <= '0;
            r_fwgt[1]   <= '0;
            r_flast[0]  <= 1'b0;
            r_flast[1]  <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_infl      <= w_issue;
            r_infl_last <= w_issue && (r_cursor + ADDR_W'(1) == r_end);
            if (r_infl) begin
                r_fidx[r_wr]  <= w_index;
                r_fwgt[r_wr]  <= w_weight;
                r_flast[r_wr] <= r_infl_last;
                r_wr          <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, r_infl} - {1'b0, w_pop};
        end
    end

`ifdef CSR_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_entries;
    logic [31:0] r_perf_stalls;

    assign perf_entries = r_perf_entries;
    assign perf_stalls  = r_perf_stalls;

    // Handshake and back-pressure counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_entries <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_pop) begin
                r_perf_entries <= r_perf_entries + 32'd1;
            end
            if (w_valid && !bus.out_ready) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_csr_row_sequencer.sv
// Directed bench for csr_row_sequencer with registered memory models.
// Weight memory content: index = addr[9:0], weight = addr[7:0] + 3.
module tb_csr_row_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    csr_row_sequencer_if #(.ROW_W(10), .IDX_W(10), .WGT_W(8)) bus ();

    logic [10:0] ptr_addr;
    logic [13:0] ptr_data;
    logic [13:0] w_addr;
    logic [9:0]  w_index;
    logic [7:0]  w_weight;
    logic        row_done;
    logic        err_bad_row;
`ifdef CSR_SEQ_PERF_CNT_EN
    logic [31:0] perf_entries;
    logic [31:0] perf_stalls;
`endif

    int errors = 0;
    int checks = 0;
    logic [13:0] ptr_mem [0:2047];

    csr_row_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ptr_addr    (ptr_addr),
        .ptr_data    (ptr_data),
        .w_addr      (w_addr),
        .w_index     (w_index),
        .w_weight    (w_weight),
        .row_done    (row_done),
        .err_bad_row (err_bad_row)
`ifdef CSR_SEQ_PERF_CNT_EN
        ,
        .perf_entries(perf_entries),
        .perf_stalls (perf_stalls)
`endif
    );

    function automatic logic [9:0] f_idx(input logic [13:0] a);
        return a[9:0];
    endfunction

    function automatic logic [7:0] f_wgt(input logic [13:0] a);
        return a[7:0] + 8'd3;
    endfunction

    always @(posedge clk) begin
        ptr_data <= ptr_mem[ptr_addr];
        w_index  <= f_idx(w_addr);
        w_weight <= f_wgt(w_addr);
    end

    task automatic send_row(input int id);
        int n;
        n = 0;
        @(negedge clk);
        bus.row_valid = 1'b1;
        bus.row_id    = 10'(id);
        while (!bus.row_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.row_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept row %0d: row_ready=%b want 1", id, bus.row_ready);
        end
        @(negedge clk);
        bus.row_valid = 1'b0;
    endtask

    // Starts at the negedge one cycle after accept.
    task automatic collect(input string nm, input int beg, input int en,
                           input bit stall_mode, output int stalls);
        int nexp, nout, done_k, last_k, iss;
        bit prev_stall;
        logic [9:0] p_idx;
        logic [7:0] p_wgt;
        logic p_last;
        logic [13:0] a;
        logic [5:0] pat;
        pat = 6'b101001;
        nexp = (en > beg) ? en - beg : 0;
        nout = 0; done_k = 0; last_k = 0; prev_stall = 0; stalls = 0;
        p_idx = '0; p_wgt = '0; p_last = 1'b0;
        for (int k = 1; k <= 60 && done_k == 0; k++) begin
            bus.out_ready = stall_mode ? pat[(k - 1) % 6] : 1'b1;
            if (prev_stall && bus.out_valid) begin
                checks++;
                if ({bus.out_index, bus.out_weight, bus.out_last} !==
                    {p_idx, p_wgt, p_last}) begin
                    errors++;
                    $display("FAIL %s stable: got %h/%h/%b want %h/%h/%b", nm,
                             bus.out_index, bus.out_weight, bus.out_last,
                             p_idx, p_wgt, p_last);
                end
            end
            prev_stall = 1'b0;
            if (en > beg && k >= 3) begin
                iss = int'(w_addr) - beg;
                checks++;
                if (iss - nout < 0 || iss - nout > 2) begin
                    errors++;
                    $display("FAIL %s ahead: issued %0d popped %0d", nm, iss, nout);
                end
                if (!stall_mode) begin
                    checks++;
                    if (int'(w_addr) != ((beg + (k > 4 ? k - 4 : 0)) < en ?
                                         beg + (k > 4 ? k - 4 : 0) : en)) begin
                        errors++;
                        $display("FAIL %s w_addr k=%0d: got %0d", nm, k, w_addr);
                    end
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                prev_stall = 1'b1;
                p_idx = bus.out_index;
                p_wgt = bus.out_weight;
                p_last = bus.out_last;
            end
            if (bus.out_valid && bus.out_ready) begin
                a = 14'(beg + nout);
                checks++;
                if (nout >= nexp) begin
                    errors++;
                    $display("FAIL %s extra entry: got %0d entries want %0d", nm, nout + 1, nexp);
                end else if (bus.out_index !== f_idx(a) || bus.out_weight !== f_wgt(a)
                             || bus.out_last !== (nout == nexp - 1)) begin
                    errors++;
                    $display("FAIL %s entry %0d: got %h/%h/%b want %h/%h/%b", nm, nout,
                             bus.out_index, bus.out_weight, bus.out_last,
                             f_idx(a), f_wgt(a), (nout == nexp - 1));
                end
                if (!stall_mode) begin
                    checks++;
                    if (k != 6 + nout) begin
                        errors++;
                        $display("FAIL %s entry time: got k=%0d want %0d", nm, k, 6 + nout);
                    end
                end
                nout++;
                last_k = k;
            end
            if (row_done === 1'b1) done_k = k;
            if (done_k == 0) @(negedge clk);
        end
        checks++;
        if (nout != nexp) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", nm, nout, nexp);
        end
        checks++;
        if (done_k != ((nexp > 0) ? last_k + 1 : 4)) begin
            errors++;
            $display("FAIL %s row_done time: got %0d want %0d", nm, done_k,
                     (nexp > 0) ? last_k + 1 : 4);
        end
        @(negedge clk);
        checks++;
        if (row_done !== 1'b0 || bus.row_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after done: row_done=%b row_ready=%b want 0/1", nm,
                     row_done, bus.row_ready);
        end
    endtask

    task automatic test_reset();
        bus.row_valid = 1'b0;
        bus.row_id    = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.row_ready, bus.out_valid, bus.out_last, row_done, err_bad_row} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b want 00000",
                     {bus.row_ready, bus.out_valid, bus.out_last, row_done, err_bad_row});
        end
        checks++;
        if (ptr_addr !== 11'd0 || w_addr !== 14'd0) begin
            errors++;
            $display("FAIL reset addr: ptr_addr=%0d w_addr=%0d want 0/0", ptr_addr, w_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.row_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release row_ready: got %b want 1", bus.row_ready);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_basic();
        int s;
        send_row(5);
        collect("basic", 100, 103, 1'b0, s);
    endtask

    task automatic test_empty();
        int s;
        send_row(7);
        collect("empty", 200, 200, 1'b0, s);
        checks++;
        if (err_bad_row !== 1'b0) begin
            errors++;
            $display("FAIL empty err_bad_row: got %b want 0", err_bad_row);
        end
    endtask

    task automatic test_bad_row();
        int s;
        send_row(9);
        collect("bad", 50, 40, 1'b0, s);
        checks++;
        if (err_bad_row !== 1'b1) begin
            errors++;
            $display("FAIL bad err_bad_row: got %b want 1", err_bad_row);
        end
        send_row(5);
        collect("after_bad", 100, 103, 1'b0, s);
        checks++;
        if (err_bad_row !== 1'b1) begin
            errors++;
            $display("FAIL sticky err_bad_row: got %b want 1", err_bad_row);
        end
    endtask

    task automatic test_stall();
        int s;
`ifdef CSR_SEQ_PERF_CNT_EN
        logic [31:0] e0, s0;
        e0 = perf_entries;
        s0 = perf_stalls;
`endif
        send_row(11);
        collect("stall", 300, 306, 1'b1, s);
        bus.out_ready = 1'b1;
`ifdef CSR_SEQ_PERF_CNT_EN
        checks++;
        if (perf_entries - e0 !== 32'd6) begin
            errors++;
            $display("FAIL perf_entries: got %0d want 6", perf_entries - e0);
        end
        checks++;
        if (perf_stalls - s0 !== 32'(s)) begin
            errors++;
            $display("FAIL perf_stalls: got %0d want %0d", perf_stalls - s0, s);
        end
`endif
    endtask

    task automatic test_top_of_memory();
        int s;
        send_row(13);
        collect("top", 16380, 16383, 1'b0, s);
    endtask

    task automatic test_reset_mid();
        int n, s;
        bit seen;
        n = 0;
        send_row(15);
        for (int k = 0; k < 30 && n < 2; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_index !== f_idx(14'(500 + n))) begin
                    errors++;
                    $display("FAIL midrst entry %0d: got %0d want %0d", n,
                             bus.out_index, 500 + n);
                end
                n++;
            end
            if (n < 2) @(negedge clk);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL midrst entries before reset: got %0d want 2", n);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.row_ready, row_done, err_bad_row} !== 5'b0
            || bus.out_index !== 10'd0 || bus.out_weight !== 8'd0 || ptr_addr !== 11'd0) begin
            errors++;
            $display("FAIL midrst outputs: flags=%b idx=%0d wgt=%0d ptr=%0d want 0",
                     {bus.out_valid, bus.out_last, bus.row_ready, row_done, err_bad_row},
                     bus.out_index, bus.out_weight, ptr_addr);
        end
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (row_done !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (row_done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst row_done: got pulse want none");
        end
        send_row(5);
        collect("post_rst", 100, 103, 1'b0, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) ptr_mem[i] = '0;
        ptr_mem[5]  = 14'd100;
        ptr_mem[6]  = 14'd103;
        ptr_mem[7]  = 14'd200;
        ptr_mem[8]  = 14'd200;
        ptr_mem[9]  = 14'd50;
        ptr_mem[10] = 14'd40;
        ptr_mem[11] = 14'd300;
        ptr_mem[12] = 14'd306;
        ptr_mem[13] = 14'd16380;
        ptr_mem[14] = 14'd16383;
        ptr_mem[15] = 14'd500;
        ptr_mem[16] = 14'd505;
        test_reset();
        test_basic();
        test_empty();
        test_bad_row();
        test_stall();
        test_top_of_memory();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
